// File: rtl/halt_pkg.sv
// Shared types and constants for the halt/trap sequencer.
//   state_e  : sequencer states (RUN, DRAIN, REPORT, DONE)
//   cause_e  : halt cause encoding reported to the simulation wrapper
//   INST_EBREAK / HALT_CODE_BAD : trap instruction word and error return code
package halt_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_REPORT = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_EBREAK  = 2'd0,
        CAUSE_ILLEGAL = 2'd1,
        CAUSE_TIMEOUT = 2'd2
    } cause_e;

    localparam logic [31:0] INST_EBREAK   = 32'h0010_0073;
    localparam logic [31:0] HALT_CODE_BAD = 32'hFFFF_FFFF;

endpackage

// File: rtl/halt_txn_counter.sv
// Outstanding memory transaction counter.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   req_i        : request accepted this cycle (+1)
//   resp_i       : response returned this cycle (-1)
//   empty_o      : count after this cycle's update is zero
//   ovf_o        : request while already at MAX_OUT (count holds)
//   unf_o        : response while at zero (count holds)
module halt_txn_counter #(
    parameter int unsigned MAX_OUT = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_i,
    input  logic resp_i,
    output logic empty_o,
    output logic ovf_o,
    output logic unf_o
);

    localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             full_c;
    logic             zero_c;

    assign full_c = (cnt_q == CNT_W'(MAX_OUT));
    assign zero_c = (cnt_q == '0);
    assign ovf_o  = req_i & ~resp_i & full_c;
    assign unf_o  = resp_i & ~req_i & zero_c;

    // Up/down update; simultaneous req+resp cancels, illegal moves hold.
    always_comb begin
        cnt_d = cnt_q;
        if (req_i && !resp_i && !full_c) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (resp_i && !req_i && !zero_c) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Look-ahead so a final response can release the drain in the same cycle.
    assign empty_o = (cnt_d == '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/halt_ctrl.sv
// Halt/trap sequencer: detects ebreak, all-zero instruction or commit
// watchdog timeout, stalls fetch, drains outstanding memory traffic and
// presents a single halt report to the simulation wrapper.
//   clock, reset        : clock, asynchronous active-high reset
//   commit_*            : retiring instruction word / PC, valid strobe
//   gpr_a0              : x10, return code source for ebreak
//   mem_req_fire/resp   : memory request / response handshakes
//   halt_ack            : wrapper consumed the report
//   stall_fetch         : high whenever not in RUN
//   halt_valid/cause/code/pc : halt report (valid only in REPORT)
//   done                : sequence finished, sticky until reset
module halt_ctrl
    import halt_pkg::*;
#(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned WDOG_W  = 20,
    parameter int unsigned MAX_OUT = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            commit_valid,
    input  logic [31:0]     commit_inst,
    input  logic [XLEN-1:0] commit_pc,
    input  logic [XLEN-1:0] gpr_a0,
    input  logic            mem_req_fire,
    input  logic            mem_resp_fire,
    input  logic            halt_ack,
    output logic            stall_fetch,
    output logic            halt_valid,
    output logic [1:0]      halt_cause,
    output logic [31:0]     halt_code,
    output logic [XLEN-1:0] halt_pc,
    output logic            done
);

    state_e            state_q,   state_d;
    logic [WDOG_W-1:0] wdog_q,    wdog_d;
    logic [WDOG_W-1:0] wdog_inc;
    logic [XLEN-1:0]   last_pc_q, last_pc_d;
    cause_e            cause_q,   cause_d;
    logic [31:0]       code_q,    code_d;
    logic [XLEN-1:0]   pc_q,      pc_d;

    logic txn_empty;
    logic txn_ovf;
    logic txn_unf;
    logic unused_a0_hi;

    assign unused_a0_hi = ^gpr_a0[XLEN-1:32];

    halt_txn_counter #(
        .MAX_OUT (MAX_OUT)
    ) u_txn (
        .clk_i   (clock),
        .rst_i   (reset),
        .req_i   (mem_req_fire),
        .resp_i  (mem_resp_fire),
        .empty_o (txn_empty),
        .ovf_o   (txn_ovf),
        .unf_o   (txn_unf)
    );

    assign wdog_inc = wdog_q + WDOG_W'(1);

    // Next-state, watchdog and report capture.
    always_comb begin
        state_d   = state_q;
        wdog_d    = wdog_q;
        last_pc_d = last_pc_q;
        cause_d   = cause_q;
        code_d    = code_q;
        pc_d      = pc_q;

        case (state_q)
            ST_RUN: begin
                if (commit_valid) begin
                    // Any commit clears the watchdog, so a trap on the expiry cycle wins.
                    wdog_d    = '0;
                    last_pc_d = commit_pc;
                    if (commit_inst == INST_EBREAK) begin
                        cause_d = CAUSE_EBREAK;
                        code_d  = gpr_a0[31:0];
                        pc_d    = commit_pc;
                        state_d = ST_DRAIN;
                    end else if (commit_inst == 32'h0) begin
                        cause_d = CAUSE_ILLEGAL;
                        code_d  = HALT_CODE_BAD;
                        pc_d    = commit_pc;
                        state_d = ST_DRAIN;
                    end
                end else begin
                    wdog_d = wdog_inc;
                    if (wdog_inc == '1) begin
                        cause_d = CAUSE_TIMEOUT;
                        code_d  = HALT_CODE_BAD;
                        pc_d    = last_pc_q;
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (txn_empty) begin
                    state_d = ST_REPORT;
                end
            end
            ST_REPORT: begin
                if (halt_ack) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_RUN;
            wdog_q    <= '0;
            last_pc_q <= '0;
            cause_q   <= CAUSE_EBREAK;
            code_q    <= '0;
            pc_q      <= '0;
        end else begin
            state_q   <= state_d;
            wdog_q    <= wdog_d;
            last_pc_q <= last_pc_d;
            cause_q   <= cause_d;
            code_q    <= code_d;
            pc_q      <= pc_d;
        end
    end

    assign stall_fetch = (state_q != ST_RUN);
    assign halt_valid  = (state_q == ST_REPORT);
    assign done        = (state_q == ST_DONE);
    assign halt_cause  = cause_q;
    assign halt_code   = code_q;
    assign halt_pc     = pc_q;

    // Memory protocol violations: the counter holds, but these must never happen.
    a_no_txn_ovf: assert property (@(posedge clock) disable iff (reset) !txn_ovf);
    a_no_txn_unf: assert property (@(posedge clock) disable iff (reset) !txn_unf);

endmodule

// File: doc/halt_ctrl.md
# halt_ctrl

Halt/trap sequencer for the NPC simulation top. It watches the commit stream for `ebreak` (32'h00100073), an all-zero instruction, or a commit watchdog timeout, and then sequences shutdown: it stalls fetch, drains outstanding memory transactions, and captures the a0 return code and PC. It then presents one halt report to the simulation wrapper, which performs the DPI halt call and `$finish`.

## Interface
Parameters:
- `XLEN`, 64, GPR/PC width.
- `WDOG_W`, 20, watchdog counter width; timeout after 2^WDOG_W−1 consecutive cycles without a commit.
- `MAX_OUT`, 4, maximum outstanding memory transactions.

Ports:
- `clock` in 1: single clock; all state on rising edge.
- `reset` in 1: asynchronous, active-high.
- `commit_valid` in 1: one instruction retires this cycle.
- `commit_inst` in 32: retiring instruction word.
- `commit_pc` in XLEN: retiring PC.
- `gpr_a0` in XLEN: current value of x10, valid on the commit cycle.
- `mem_req_fire` in 1: memory request accepted this cycle.
- `mem_resp_fire` in 1: memory response returned this cycle.
- `halt_ack` in 1: wrapper has consumed the halt report.
- `stall_fetch` out 1: freeze fetch, and so the commit stream.
- `halt_valid` out 1: halt report present.
- `halt_cause` out 2: 0 EBREAK, 1 ILLEGAL (inst==0), 2 TIMEOUT.
- `halt_code` out 32: `gpr_a0[31:0]` for EBREAK; 32'hFFFF_FFFF for ILLEGAL and TIMEOUT.
- `halt_pc` out XLEN: PC of the trapping commit; for TIMEOUT, the last committed PC (0 if none).
- `done` out 1: sequence complete; sticky until reset.

## Operation
- States: RUN, DRAIN, REPORT, DONE. Reset enters RUN.
- **RUN**
  - Each cycle with `commit_valid` records `commit_pc` as last-PC and clears the watchdog. Other cycles increment the watchdog.
  - Commit of EBREAK or 32'h0: latch cause, code and PC, then go to DRAIN.
  - Watchdog reaching all-ones with no commit that cycle: latch TIMEOUT, then go to DRAIN.
  - A trap commit in the expiry cycle wins, because the commit clears the watchdog.
- **DRAIN**
  - Waits until the outstanding count is 0, then goes to REPORT.
  - Commits are ignored.
  - The watchdog is frozen.
- **REPORT**
  - `halt_valid`=1. Cause, code and PC are held stable.
  - `halt_ack` moves to DONE.
- **DONE**
  - `done`=1, `stall_fetch`=1, `halt_valid`=0.
  - All inputs are ignored until reset.
- **Outstanding counter** (width $clog2(MAX_OUT+1))
  - req only: +1. resp only: −1. Both or neither: unchanged.
  - req at MAX_OUT: count holds; this is a protocol violation, flagged by assertion.
  - resp at 0: count holds; assertion.
- **Reset mid-sequence** (any state): returns to RUN, with all counters and latches cleared.

## Timing
- Reset values of all outputs are 0: `stall_fetch`, `halt_valid`, `halt_cause`, `halt_code`, `halt_pc`, `done`.
- All outputs are registered or decoded from registered state. `stall_fetch` = (state != RUN).
- Trap commit in cycle N:
  - state=DRAIN and `stall_fetch`=1 from N+1.
  - If the count is 0 at N+1, REPORT (`halt_valid`=1) at N+2.
  - Each extra cycle of draining delays REPORT by one cycle.
- A response arriving in cycle M that brings the count to 0 gives REPORT at M+1.
- `halt_ack` sampled high in REPORT cycle K gives DONE at K+1. Ack in the first REPORT cycle is legal.
- `halt_ack` outside REPORT has no effect.
- Watchdog expiry: a count that becomes all-ones in cycle T gives DRAIN at T+1.

## Structure
- Package `halt_pkg`:
  - state enum.
  - cause enum (EBREAK=0, ILLEGAL=1, TIMEOUT=2).
  - `INST_EBREAK` = 32'h00100073.
  - `HALT_CODE_BAD` = 32'hFFFF_FFFF.
- Sub-module `halt_txn_counter`: the outstanding up/down counter. It has a MAX_OUT parameter and outputs `empty` plus the two violation flags.
- The top holds the FSM, watchdog and capture registers.

## Test plan
- EBREAK commit, PC 0x8000_0010, a0 0x0, no outstanding transactions → `halt_valid` 2 cycles later with cause 0, code 0, pc 0x8000_0010. Ack → `done`=1 next cycle.
- 3 requests outstanding, EBREAK with a0 0x1, responses on following cycles N+3, N+5, N+6 → `halt_valid` only at N+7. `stall_fetch` high from N+1.
- Commit of 32'h0 at PC 0x8000_0100 → cause 1, code 0xFFFF_FFFF.
- `WDOG_W`=4, one commit at PC 0x8000_0004, then none → TIMEOUT: DRAIN at the 15th idle cycle, then cause 2, pc 0x8000_0004. A second run with an EBREAK committed exactly on the expiry cycle → cause 0.
- Simultaneous req+resp with the count at 1 → count stays 1. Resp at 0 → count 0 and assertion fires.
- Reset asserted during DRAIN and during REPORT → all outputs 0 asynchronously. A normal EBREAK sequence afterwards completes correctly.
